// File: rtl/comm_frame_deserializer.sv
// Serial frame receiver for the pong link: start, DATA_BITS payload (LSB first),
// even parity, stop. Each good frame is handed to the message decoder via valid/ack.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on sync_in
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling payload bits at each bit-period boundary
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit and deciding accept/drop
// WAIT_IDLE | framing error seen; hold until the line returns high
module comm_frame_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] message_word,
  output logic                 message_valid,
  input  logic                 message_acked,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);
  localparam logic [TIMER_W-1:0] FULL_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]   LAST_BIT  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t               state, state_next;
  logic                 sync_meta, sync_in;
  logic [TIMER_W-1:0]   timer;
  logic [IDX_W-1:0]     bit_index;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_ok;
  logic                 bit_tick;
  logic                 accept, parity_fail, frame_fail, overrun_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_in   <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync_in   <= sync_meta;
    end
  end

  // START samples at half a bit so the following full-period samples land mid-bit.
  always_comb begin
    bit_tick = 1'b0;
    if (state == START)
      bit_tick = (timer == HALF_LAST);
    else if (state inside {DATA, PARITY, STOP})
      bit_tick = (timer == FULL_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!sync_in) state_next = START;
      START:     if (bit_tick) state_next = sync_in ? IDLE : DATA;
      DATA:      if (bit_tick && bit_index == LAST_BIT) state_next = PARITY;
      PARITY:    if (bit_tick) state_next = STOP;
      STOP:      if (bit_tick) state_next = sync_in ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (sync_in) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_fail  = 1'b0;
    parity_fail = 1'b0;
    accept      = 1'b0;
    overrun_hit = 1'b0;
    if (state == STOP && bit_tick) begin
      if (!sync_in)
        frame_fail = 1'b1;
      else if (!parity_ok)
        parity_fail = 1'b1;
      else if (!message_valid || message_acked)
        accept = 1'b1;
      else
        overrun_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      parity_ok <= 1'b0;
    end else begin
      if (state_next != state || bit_tick)
        timer <= '0;
      else if (state != IDLE && state != WAIT_IDLE)
        timer <= timer + TIMER_W'(1);

      if (state != DATA)
        bit_index <= '0;
      else if (bit_tick)
        bit_index <= bit_index + IDX_W'(1);

      if (state == DATA && bit_tick)
        shift_reg <= {sync_in, shift_reg[DATA_BITS-1:1]};

      if (state == PARITY && bit_tick)
        parity_ok <= ~(^shift_reg ^ sync_in);
    end
  end

  // A same-cycle ack and acceptance reloads the word without dropping valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      message_word  <= '0;
      message_valid <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= parity_fail;
      framing_error <= frame_fail;
      overrun       <= overrun_hit;
      if (accept) begin
        message_word  <= shift_reg;
        message_valid <= 1'b1;
      end else if (message_acked) begin
        message_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_comm_frame_deserializer.sv
// Directed bench for comm_frame_deserializer at 4 clocks per bit, 24 data bits.
module tb_comm_frame_deserializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b1;
  logic [23:0] message_word;
  logic        message_valid;
  logic        message_acked = 1'b0;
  logic        parity_error, framing_error, overrun;

  int total = 0;
  int bad   = 0;
  int n_par = 0, n_frm = 0, n_ovr = 0, n_fall = 0, n_coinc = 0;
  logic prev_valid = 1'b0;

  comm_frame_deserializer #(.CLKS_PER_BIT(4), .DATA_BITS(24)) dut (
    .clock         (clock),
    .reset         (reset),
    .serial_in     (serial_in),
    .message_word  (message_word),
    .message_valid (message_valid),
    .message_acked (message_acked),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (parity_error)  n_par++;
    if (framing_error) n_frm++;
    if (overrun)       n_ovr++;
    if (prev_valid && !message_valid) n_fall++;
    if ((32'(parity_error) + 32'(framing_error) + 32'(overrun)) > 1 ||
        ((parity_error || framing_error || overrun) && message_valid && !prev_valid))
      n_coinc++;
    prev_valid = message_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Leaves the line at the stop value; callers restore idle after a bad stop.
  task automatic send_frame(input logic [23:0] d, input logic par, input logic stp);
    drive_bit(1'b0, 4);
    for (int i = 0; i < 24; i++) drive_bit(d[i], 4);
    drive_bit(par, 4);
    drive_bit(stp, 4);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 8 && !message_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check(tag, 32'(message_valid), 32'd1);
  endtask

  task automatic do_ack();
    message_acked = 1'b1;
    @(posedge clock);
    #1;
    message_acked = 1'b0;
  endtask

  initial begin
    logic [23:0] d;
    int fall_snap;

    #2;
    check("rst_valid", 32'(message_valid), 32'd0);
    check("rst_word",  32'(message_word),  32'd0);
    check("rst_perr",  32'(parity_error),  32'd0);
    check("rst_ferr",  32'(framing_error), 32'd0);
    check("rst_ovr",   32'(overrun),       32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    drive_bit(1'b1, 6);

    // clean frame, 12 ones -> parity 0
    send_frame(24'h0F3CA5, 1'b0, 1'b1);
    check("clean_early", 32'(message_valid), 32'd0);
    @(posedge clock); #1;
    check("clean_valid_t1", 32'(message_valid), 32'd1);
    check("clean_word", 32'(message_word), 32'h0F3CA5);
    check("clean_errs", 32'(n_par + n_frm + n_ovr), 32'd0);
    do_ack();
    check("ack_clears", 32'(message_valid), 32'd0);
    drive_bit(1'b1, 4);

    // parity fault: one data one needs parity 1, send 0
    send_frame(24'h000001, 1'b0, 1'b1);
    drive_bit(1'b1, 4);
    check("par_pulse_cnt", 32'(n_par), 32'd1);
    check("par_valid", 32'(message_valid), 32'd0);
    check("par_word", 32'(message_word), 32'h0F3CA5);

    // framing fault: 9 ones -> parity 1, stop 0, line stuck low
    send_frame(24'h123456, 1'b1, 1'b0);
    drive_bit(1'b0, 20);
    check("frm_pulse_cnt", 32'(n_frm), 32'd1);
    check("frm_valid", 32'(message_valid), 32'd0);
    drive_bit(1'b1, 8);
    check("frm_no_retrig", 32'(n_par + n_frm + n_ovr), 32'd2);
    send_frame(24'hABCDEF, 1'b1, 1'b1);
    wait_valid("after_frm_valid");
    check("after_frm_word", 32'(message_word), 32'hABCDEF);
    check("after_frm_errs", 32'(n_par + n_frm + n_ovr), 32'd2);
    do_ack();
    drive_bit(1'b1, 4);

    // overrun: A accepted and left unacked, B dropped
    send_frame(24'h111111, 1'b0, 1'b1);
    wait_valid("ovr_a_valid");
    drive_bit(1'b1, 4);
    send_frame(24'h222222, 1'b0, 1'b1);
    drive_bit(1'b1, 4);
    check("ovr_pulse_cnt", 32'(n_ovr), 32'd1);
    check("ovr_word_kept", 32'(message_word), 32'h111111);
    check("ovr_valid_kept", 32'(message_valid), 32'd1);

    // ack in B's stop-sample cycle: reload, no gap
    fall_snap = n_fall;
    send_frame(24'h222222, 1'b0, 1'b1);
    do_ack();
    drive_bit(1'b1, 4);
    check("simul_word", 32'(message_word), 32'h222222);
    check("simul_valid", 32'(message_valid), 32'd1);
    check("simul_no_gap", 32'(n_fall), 32'(fall_snap));
    check("simul_no_ovr", 32'(n_ovr), 32'd1);
    do_ack();
    check("simul_ack", 32'(message_valid), 32'd0);
    drive_bit(1'b1, 4);

    // one-cycle glitch
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 12);
    check("glitch_valid", 32'(message_valid), 32'd0);
    check("glitch_word", 32'(message_word), 32'h222222);
    check("glitch_errs", 32'(n_par + n_frm + n_ovr), 32'd3);

    // reset mid-frame while a word is pending
    send_frame(24'h0F3CA5, 1'b0, 1'b1);
    wait_valid("pre_rst_valid");
    drive_bit(1'b1, 4);
    d = 24'hC0FFEE;
    drive_bit(1'b0, 4);
    for (int i = 0; i < 10; i++) drive_bit(d[i], 4);
    drive_bit(d[10], 2);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(message_valid), 32'd0);
    check("midrst_word", 32'(message_word), 32'd0);
    serial_in = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    drive_bit(1'b1, 8);
    send_frame(d, ^d, 1'b1);
    wait_valid("post_rst_valid");
    check("post_rst_word", 32'(message_word), 32'hC0FFEE);
    do_ack();
    drive_bit(1'b1, 4);

    check("final_par", 32'(n_par), 32'd1);
    check("final_frm", 32'(n_frm), 32'd1);
    check("final_ovr", 32'(n_ovr), 32'd1);
    check("no_coincide", 32'(n_coinc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
